// File: rtl/pipelined_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipelined_controller: registered ID/EXE decoder with handshake, stalls,    |
// | flush, illegal flagging and multi-cycle MUL. Option: CTRL_PERF_CNT_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipelined_controller #(
    parameter int         EXE_CMD_W  = 4,
    parameter int         MUL_CYCLES = 4,
    parameter logic [3:0] MUL_CMD    = 4'b1010,
    parameter int         CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 S,
    input  logic [1:0]           mode,
    input  logic [3:0]           op_code,
    input  logic                 hazard,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [EXE_CMD_W-1:0] exe_cmd,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 wb_en,
    output logic                 S_out,
    output logic                 B,
    output logic                 mul_busy,
    output logic                 illegal
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     issue_cnt,
    output logic [CNT_W-1:0]     stall_cnt
`endif
);

    localparam logic [1:0] c_ARITH_MODE  = 2'b00;
    localparam logic [1:0] c_MEM_MODE    = 2'b01;
    localparam logic [1:0] c_BRANCH_MODE = 2'b10;

    localparam logic [3:0] c_MOV_OP = 4'b1101;
    localparam logic [3:0] c_MVN_OP = 4'b1111;
    localparam logic [3:0] c_ADD_OP = 4'b0100;
    localparam logic [3:0] c_ADC_OP = 4'b0101;
    localparam logic [3:0] c_SUB_OP = 4'b0010;
    localparam logic [3:0] c_SBC_OP = 4'b0110;
    localparam logic [3:0] c_AND_OP = 4'b0000;
    localparam logic [3:0] c_ORR_OP = 4'b1100;
    localparam logic [3:0] c_EOR_OP = 4'b0001;
    localparam logic [3:0] c_CMP_OP = 4'b1010;
    localparam logic [3:0] c_TST_OP = 4'b1000;

    localparam logic [3:0] c_MOV_EXE = 4'b0001;
    localparam logic [3:0] c_MVN_EXE = 4'b1001;
    localparam logic [3:0] c_ADD_EXE = 4'b0010;
    localparam logic [3:0] c_ADC_EXE = 4'b0011;
    localparam logic [3:0] c_SUB_EXE = 4'b0100;
    localparam logic [3:0] c_SBC_EXE = 4'b0101;
    localparam logic [3:0] c_AND_EXE = 4'b0110;
    localparam logic [3:0] c_ORR_EXE = 4'b0111;
    localparam logic [3:0] c_EOR_EXE = 4'b1000;
    localparam logic [3:0] c_TST_EXE = 4'b0110;

    localparam logic [7:0] c_MUL_LOAD = 8'(MUL_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_mul_cnt;
    logic       r_mul_s;

    logic [3:0] w_cmd;
    logic       w_mr;
    logic       w_mw;
    logic       w_wb;
    logic       w_so;
    logic       w_b;
    logic       w_ill;
    logic       w_is_mul;
    logic       w_accept;

    assign in_ready = rst_n & (r_state == ST_RUN) & ~hazard & ~flush;
    assign w_accept = in_valid & in_ready;
    assign w_is_mul = (mode == 2'b11) && (op_code == 4'b0000);

    always_comb begin
        w_cmd = 4'b0000;
        w_mr  = 1'b0;
        w_mw  = 1'b0;
        w_wb  = 1'b0;
        w_so  = S;
        w_b   = 1'b0;
        w_ill = 1'b0;
        case (mode)
            c_ARITH_MODE: begin
                w_wb = 1'b1;
                case (op_code)
                    c_MOV_OP: w_cmd = c_MOV_EXE;
                    c_MVN_OP: w_cmd = c_MVN_EXE;
                    c_ADD_OP: w_cmd = c_ADD_EXE;
                    c_ADC_OP: w_cmd = c_ADC_EXE;
                    c_SUB_OP: w_cmd = c_SUB_EXE;
                    c_SBC_OP: w_cmd = c_SBC_EXE;
                    c_AND_OP: w_cmd = c_AND_EXE;
                    c_ORR_OP: w_cmd = c_ORR_EXE;
                    c_EOR_OP: w_cmd = c_EOR_EXE;
                    c_CMP_OP: begin
                        w_cmd = c_SUB_EXE;
                        w_wb  = 1'b0;
                        w_so  = 1'b1;
                    end
                    c_TST_OP: begin
                        w_cmd = c_TST_EXE;
                        w_wb  = 1'b0;
                        w_so  = 1'b1;
                    end
                    default:  w_ill = 1'b1;
                endcase
            end
            c_MEM_MODE: begin
                w_cmd = c_ADD_EXE;
                w_mr  = S;
                w_mw  = ~S;
                w_wb  = S;
            end
            c_BRANCH_MODE: w_b = 1'b1;
            default: begin
                if (op_code == 4'b0000) begin
                    w_cmd = MUL_CMD;
                    w_wb  = 1'b1;
                end else begin
                    w_ill = 1'b1;
                end
            end
        endcase
        // An undefined encoding still issues, but with every control forced off.
        if (w_ill) begin
            w_cmd = 4'b0000;
            w_mr  = 1'b0;
            w_mw  = 1'b0;
            w_wb  = 1'b0;
            w_so  = 1'b0;
            w_b   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_mul_cnt <= 8'd0;
            r_mul_s   <= 1'b0;
            out_valid <= 1'b0;
            exe_cmd   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            wb_en     <= 1'b0;
            S_out     <= 1'b0;
            B         <= 1'b0;
            mul_busy  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            exe_cmd   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            wb_en     <= 1'b0;
            S_out     <= 1'b0;
            B         <= 1'b0;
            mul_busy  <= 1'b0;
            illegal   <= 1'b0;
            if (flush) begin
                r_state   <= ST_RUN;
                r_mul_cnt <= 8'd0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_accept) begin
                            if (w_is_mul && (MUL_CYCLES > 1)) begin
                                r_state   <= ST_MUL;
                                r_mul_cnt <= c_MUL_LOAD;
                                r_mul_s   <= S;
                                mul_busy  <= 1'b1;
                            end else begin
                                out_valid <= 1'b1;
                                exe_cmd   <= EXE_CMD_W'(w_cmd);
                                mem_read  <= w_mr;
                                mem_write <= w_mw;
                                wb_en     <= w_wb;
                                S_out     <= w_so;
                                B         <= w_b;
                                illegal   <= w_ill;
                            end
                        end
                    end
                    ST_MUL: begin
                        if (r_mul_cnt == 8'd1) begin
                            r_state   <= ST_RUN;
                            r_mul_cnt <= 8'd0;
                            out_valid <= 1'b1;
                            exe_cmd   <= EXE_CMD_W'(MUL_CMD);
                            wb_en     <= 1'b1;
                            S_out     <= r_mul_s;
                        end else begin
                            r_mul_cnt <= r_mul_cnt - 8'd1;
                            mul_busy  <= 1'b1;
                        end
                    end
                    default: r_state <= ST_RUN;
                endcase
            end
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (w_accept && (issue_cnt != '1)) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (in_valid && !in_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_controller.sv
`default_nettype none
// Testbench for pipelined_controller: directed steps then randomized traffic
// checked against a cycle-timestamped behavioural model.
module tb_pipelined_controller;

    localparam int         EXE_CMD_W  = 4;
    localparam int         MUL_CYCLES = 4;
    localparam logic [3:0] MUL_CMD    = 4'b1010;
    localparam int         CNT_W      = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 S = 1'b0;
    logic [1:0]           mode = 2'b00;
    logic [3:0]           op_code = 4'b0000;
    logic                 hazard = 1'b0;
    logic                 flush = 1'b0;
    logic                 in_ready;
    logic                 out_valid;
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic                 mem_read, mem_write, wb_en, S_out, B, mul_busy, illegal;
`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0]     issue_cnt, stall_cnt;
    localparam int        CAP = (1 << CNT_W) - 1;
    int                   exp_issue = 0;
    int                   exp_stall = 0;
`endif

    pipelined_controller #(
        .EXE_CMD_W (EXE_CMD_W),
        .MUL_CYCLES(MUL_CYCLES),
        .MUL_CMD   (MUL_CMD),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .S        (S),
        .mode     (mode),
        .op_code  (op_code),
        .hazard   (hazard),
        .flush    (flush),
        .out_valid(out_valid),
        .exe_cmd  (exe_cmd),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .wb_en    (wb_en),
        .S_out    (S_out),
        .B        (B),
        .mul_busy (mul_busy),
        .illegal  (illegal)
`ifdef CTRL_PERF_CNT_EN
        ,
        .issue_cnt(issue_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ov;
        logic [3:0] cmd;
        logic       mr;
        logic       mw;
        logic       wb;
        logic       so;
        logic       b;
        logic       busy;
        logic       ill;
    } exp_t;

    localparam exp_t BUBBLE = '0;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q = '0;
    int   cyc = 0;
    bit   pend = 1'b0;
    int   due = 0;
    logic pend_s = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference decode table written straight from the instruction set rules.
    function automatic exp_t decode(input logic [1:0] m, input logic [3:0] op, input logic s);
        exp_t e;
        e    = BUBBLE;
        e.ov = 1'b1;
        e.so = s;
        if (m == 2'b00) begin
            e.wb = 1'b1;
            case (op)
                4'b1101: e.cmd = 4'b0001;
                4'b1111: e.cmd = 4'b1001;
                4'b0100: e.cmd = 4'b0010;
                4'b0101: e.cmd = 4'b0011;
                4'b0010: e.cmd = 4'b0100;
                4'b0110: e.cmd = 4'b0101;
                4'b0000: e.cmd = 4'b0110;
                4'b1100: e.cmd = 4'b0111;
                4'b0001: e.cmd = 4'b1000;
                4'b1010: begin e.cmd = 4'b0100; e.wb = 1'b0; e.so = 1'b1; end
                4'b1000: begin e.cmd = 4'b0110; e.wb = 1'b0; e.so = 1'b1; end
                default: begin e = BUBBLE; e.ov = 1'b1; e.ill = 1'b1; end
            endcase
        end else if (m == 2'b01) begin
            e.cmd = 4'b0010;
            e.mr  = s;
            e.mw  = !s;
            e.wb  = s;
        end else if (m == 2'b10) begin
            e.b = 1'b1;
        end else if (op == 4'b0000) begin
            e.cmd = MUL_CMD;
            e.wb  = 1'b1;
        end else begin
            e = BUBBLE; e.ov = 1'b1; e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.ov));
        chk({tag, ".exe_cmd"},   32'(exe_cmd),   32'(exp_q.cmd));
        chk({tag, ".mem_read"},  32'(mem_read),  32'(exp_q.mr));
        chk({tag, ".mem_write"}, 32'(mem_write), 32'(exp_q.mw));
        chk({tag, ".wb_en"},     32'(wb_en),     32'(exp_q.wb));
        chk({tag, ".S_out"},     32'(S_out),     32'(exp_q.so));
        chk({tag, ".B"},         32'(B),         32'(exp_q.b));
        chk({tag, ".mul_busy"},  32'(mul_busy),  32'(exp_q.busy));
        chk({tag, ".illegal"},   32'(illegal),   32'(exp_q.ill));
`ifdef CTRL_PERF_CNT_EN
        chk({tag, ".issue_cnt"}, 32'(issue_cnt), 32'(exp_issue));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
`endif
    endtask

    // One clock: drive at negedge, check in_ready, predict, check registered outputs next negedge.
    task automatic step(input string tag, input logic v, input logic [1:0] m, input logic [3:0] op,
                        input logic s, input logic hz, input logic fl);
        bit   rdy, acc, ismul;
        exp_t nxt;
        in_valid = v; mode = m; op_code = op; S = s; hazard = hz; flush = fl;
        #1;
        rdy = !pend && !hz && !fl;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        acc   = v && rdy;
        ismul = (m == 2'b11) && (op == 4'b0000);
        nxt   = BUBBLE;
        if (fl) begin
            pend = 1'b0;
        end else if (pend) begin
            if (cyc + 1 == due) begin
                nxt.ov = 1'b1; nxt.cmd = MUL_CMD; nxt.wb = 1'b1; nxt.so = pend_s;
                pend = 1'b0;
            end else begin
                nxt.busy = 1'b1;
            end
        end else if (acc && ismul && MUL_CYCLES > 1) begin
            pend = 1'b1; due = cyc + MUL_CYCLES; pend_s = s;
            nxt.busy = 1'b1;
        end else if (acc) begin
            nxt = decode(m, op, s);
        end
`ifdef CTRL_PERF_CNT_EN
        if (acc && exp_issue < CAP) exp_issue++;
        if (v && !rdy && exp_stall < CAP) exp_stall++;
`endif
        cyc++;
        exp_q = nxt;
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        pend  = 1'b0;
        exp_q = BUBBLE;
`ifdef CTRL_PERF_CNT_EN
        exp_issue = 0;
        exp_stall = 0;
`endif
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs({tag, "_rel"});
    endtask

    initial begin
        logic       v, s, hz, fl;
        logic [1:0] m;
        logic [3:0] op;

        repeat (2) @(negedge clk);
        chk("reset.in_ready", 32'(in_ready), 32'd0);
        check_outputs("reset");
        rst_n = 1'b1;

        step("add",     1'b1, 2'b00, 4'b0100, 1'b1, 1'b0, 1'b0);
        step("cmp",     1'b1, 2'b00, 4'b1010, 1'b0, 1'b0, 1'b0);
        step("tst",     1'b1, 2'b00, 4'b1000, 1'b0, 1'b0, 1'b0);
        step("str",     1'b1, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("br",      1'b1, 2'b10, 4'b0011, 1'b1, 1'b0, 1'b0);
        step("idle",    1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

        step("hz1",     1'b1, 2'b01, 4'b0000, 1'b1, 1'b1, 1'b0);
        step("hz2",     1'b1, 2'b01, 4'b0000, 1'b1, 1'b1, 1'b0);
        step("ldr",     1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 1'b0);

        step("mul",     1'b1, 2'b11, 4'b0000, 1'b1, 1'b0, 1'b0);
        step("mul_w1",  1'b1, 2'b00, 4'b0100, 1'b0, 1'b1, 1'b0);
        step("mul_w2",  1'b1, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0);
        step("mul_w3",  1'b1, 2'b00, 4'b0100, 1'b0, 1'b1, 1'b0);
        step("post",    1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

        step("fmul",    1'b1, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("fmul_w",  1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("fmul_fl", 1'b1, 2'b00, 4'b0100, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step("fmul_q", 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

        step("cmul",    1'b1, 2'b11, 4'b0000, 1'b1, 1'b0, 1'b0);
        step("cmul_w1", 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("cmul_w2", 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("cmul_fl", 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1);
        step("cmul_q",  1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

        step("ill_ar",  1'b1, 2'b00, 4'b0111, 1'b1, 1'b0, 1'b0);
        step("ill_mul", 1'b1, 2'b11, 4'b0101, 1'b1, 1'b0, 1'b0);

        step("rmul",    1'b1, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("rmul_w",  1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        do_reset("rst_mid");
        step("rst_add", 1'b1, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("rst_q", 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) step("sat", 1'b1, 2'b00, 4'b1101, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            m  = 2'($urandom_range(0, 3));
            op = 4'($urandom);
            if (m == 2'b11 && $urandom_range(0, 1) == 0) op = 4'b0000;
            s  = 1'($urandom);
            hz = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 11) == 0);
            step("rand", v, m, op, s, hz, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
